// File: rtl/fdc_sd_pkg.sv
// Shared definitions for the FDC-to-SD command sequencer: FSM encodings,
// card register map and the sector-number formatting helper.
package fdc_sd_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WR_BASE = 3'd1;
   localparam state_t ST_WR_SECT = 3'd2;
   localparam state_t ST_WR_CNT  = 3'd3;
   localparam state_t ST_WR_CTRL = 3'd4;
   localparam state_t ST_XFER    = 3'd5;
   localparam state_t ST_GAP     = 3'd6;
   localparam state_t ST_DONE    = 3'd7;

   localparam logic [31:0] SD_REG_BASE = 32'd0;
   localparam logic [31:0] SD_REG_SECT = 32'd4;
   localparam logic [31:0] SD_REG_CNT  = 32'd8;
   localparam logic [31:0] SD_REG_CTRL = 32'd12;

   localparam logic [31:0] SD_CTRL_READ  = 32'd2;
   localparam logic [31:0] SD_CTRL_WRITE = 32'd3;

   localparam int SD_SECTOR_BYTES = 512;

   // Sector register value; the 12-bit sector number wraps past 4095.
   function automatic logic [31:0] sect_word(input logic [11:0] lba, input logic [7:0] idx);
      logic [11:0] s;
      s = lba + {4'b0, idx};
      return {20'b0, s};
   endfunction

endpackage

// File: rtl/fdc_sd_sequencer_xfer_counter.sv
// Per-sector strobe tracking: byte counter, idle timeout and wrong-direction
// detection while the sequencer sits in XFER.
module sd_xfer_counter
   import fdc_sd_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       active,
   input  logic       dir_write,
   input  logic       slave_write,
   input  logic       slave_read,
   output logic [8:0] byte_cnt,
   output logic       last_byte,
   output logic       timeout,
   output logic       dir_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_q;
   logic          exp_stb;
   logic          opp_stb;

   assign exp_stb   = active & (dir_write ? slave_read  : slave_write);
   assign opp_stb   = active & (dir_write ? slave_write : slave_read);
   assign dir_err   = opp_stb;
   assign last_byte = exp_stb & ~opp_stb & (byte_cnt == 9'(SD_SECTOR_BYTES - 1));
   // tmo_q counts edges since the last reload, so an expected strobe on the
   // firing cycle reloads instead of timing out.
   assign timeout   = active & ~exp_stb & (tmo_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         tmo_q    <= TW'(1);
      end else begin
         if (clr)
            byte_cnt <= '0;
         else if (exp_stb & ~opp_stb)
            byte_cnt <= byte_cnt + 9'd1;   // wraps to 0 on the 512th strobe
         if (~active | exp_stb)
            tmo_q <= TW'(1);
         else
            tmo_q <= tmo_q + TW'(1);
      end
   end

endmodule

// File: rtl/fdc_sd_sequencer.sv
// Turns a multi-sector FDC request into SD register-block writes, then tracks
// each sector's 512-strobe burst and reports completion or timeout.
module fdc_sd_sequencer
   import fdc_sd_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'h0000_0000,
   parameter int          TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [11:0] req_lba,
   input  logic [7:0]  req_count,
   output logic        done,
   output logic        error,
   output logic        busy,
   output logic [7:0]  sector_index,
   output logic [8:0]  byte_index,
   output logic [31:0] sd_master_address,
   output logic        sd_master_write,
   output logic [31:0] sd_master_writedata,
   input  logic        sd_master_waitrequest,
   input  logic        sd_slave_write,
   input  logic        sd_slave_read
);

   state_t      state_q, state_d;
   logic        wr_q;
   logic [11:0] lba_q;
   logic [7:0]  cnt_q;
   logic [7:0]  sect_q;
   logic        err_q;
   logic        gap_q;
   logic        accept;
   logic        in_xfer;
   logic        last_byte;
   logic        timeout;
   logic        dir_err;

   assign accept  = req_valid & req_ready;
   assign in_xfer = (state_q == ST_XFER);

   sd_xfer_counter #(.TIMEOUT(TIMEOUT)) u_xfer (
      .clk         (clk),
      .rst         (rst),
      .clr         (accept),
      .active      (in_xfer),
      .dir_write   (wr_q),
      .slave_write (sd_slave_write),
      .slave_read  (sd_slave_read),
      .byte_cnt    (byte_index),
      .last_byte   (last_byte),
      .timeout     (timeout),
      .dir_err     (dir_err)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = (req_count == 8'd0) ? ST_DONE : ST_WR_BASE;
         ST_WR_BASE: if (!sd_master_waitrequest) state_d = ST_WR_SECT;
         ST_WR_SECT: if (!sd_master_waitrequest) state_d = ST_WR_CNT;
         ST_WR_CNT:  if (!sd_master_waitrequest) state_d = ST_WR_CTRL;
         ST_WR_CTRL: if (!sd_master_waitrequest) state_d = ST_XFER;
         ST_XFER: begin
            if (dir_err | timeout) state_d = ST_DONE;
            else if (last_byte)    state_d = ST_GAP;
         end
         // sect_q already holds the incremented count throughout GAP.
         ST_GAP:     if (gap_q) state_d = (sect_q == cnt_q) ? ST_DONE : ST_WR_SECT;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         lba_q   <= '0;
         cnt_q   <= '0;
         sect_q  <= '0;
         err_q   <= 1'b0;
         gap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= (state_q == ST_GAP) ? ~gap_q : 1'b0;
         if (accept) begin
            wr_q   <= req_write;
            lba_q  <= req_lba;
            cnt_q  <= req_count;
            sect_q <= '0;
            err_q  <= 1'b0;
         end
         if (in_xfer & (dir_err | timeout))
            err_q <= 1'b1;
         else if (in_xfer & last_byte)
            sect_q <= sect_q + 8'd1;
      end
   end

   always_comb begin
      sd_master_write     = 1'b0;
      sd_master_address   = '0;
      sd_master_writedata = '0;
      case (state_q)
         ST_WR_BASE: begin
            sd_master_write     = 1'b1;
            sd_master_address   = SD_REG_BASE;
            sd_master_writedata = BASE;
         end
         ST_WR_SECT: begin
            sd_master_write     = 1'b1;
            sd_master_address   = SD_REG_SECT;
            sd_master_writedata = sect_word(lba_q, sect_q);
         end
         ST_WR_CNT: begin
            sd_master_write     = 1'b1;
            sd_master_address   = SD_REG_CNT;
            sd_master_writedata = 32'd1;
         end
         ST_WR_CTRL: begin
            sd_master_write     = 1'b1;
            sd_master_address   = SD_REG_CTRL;
            sd_master_writedata = wr_q ? SD_CTRL_WRITE : SD_CTRL_READ;
         end
         default: ;
      endcase
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign error        = err_q;
   assign sector_index = sect_q;

endmodule

// File: tb/tb_fdc_sd_sequencer.sv
// Scoreboard bench: stimulus pushes expected register writes and done records;
// a negedge monitor pops and compares whenever the DUT writes or completes.
module tb_fdc_sd_sequencer;

   localparam logic [31:0] BASE_V = 32'h1234_5600;
   localparam int          TMO    = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [11:0] req_lba = '0;
   logic [7:0]  req_count = '0;
   logic        done, error, busy;
   logic [7:0]  sector_index;
   logic [8:0]  byte_index;
   logic [31:0] sd_master_address;
   logic        sd_master_write;
   logic [31:0] sd_master_writedata;
   logic        sd_master_waitrequest = 1'b0;
   logic        sd_slave_write = 1'b0;
   logic        sd_slave_read = 1'b0;

   fdc_sd_sequencer #(.BASE(BASE_V), .TIMEOUT(TMO)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_write             (req_write),
      .req_lba               (req_lba),
      .req_count             (req_count),
      .done                  (done),
      .error                 (error),
      .busy                  (busy),
      .sector_index          (sector_index),
      .byte_index            (byte_index),
      .sd_master_address     (sd_master_address),
      .sd_master_write       (sd_master_write),
      .sd_master_writedata   (sd_master_writedata),
      .sd_master_waitrequest (sd_master_waitrequest),
      .sd_slave_write        (sd_slave_write),
      .sd_slave_read         (sd_slave_read)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_done;
      logic [31:0] addr;
      logic [31:0] data;
      int          hold;
      bit          err;
      int          sidx;
      int          bidx;
      int          at;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic fail_now(input string nm, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s", nm, what);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int h);
      exp_t e;
      e = '{is_done: 1'b0, addr: a, data: d, hold: h, err: 1'b0, sidx: 0, bidx: 0, at: -1};
      sbq.push_back(e);
   endtask

   task automatic push_done(input bit er, input int si, input int bi, input int at);
      exp_t e;
      e = '{is_done: 1'b1, addr: 32'd0, data: 32'd0, hold: 0, err: er, sidx: si, bidx: bi, at: at};
      sbq.push_back(e);
   endtask

   // Monitor: stalled writes must already match the head entry every cycle.
   int   hold_cnt = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (sd_master_write === 1'b1) begin
         hold_cnt++;
         if (sbq.size() == 0 || sbq[0].is_done) begin
            fail_now("unexpected_write", $sformatf("write addr %0d, expected no write", sd_master_address));
         end else begin
            chk("wr_addr", sd_master_address, sbq[0].addr);
            chk("wr_data", sd_master_writedata, sbq[0].data);
            if (sd_master_waitrequest === 1'b0) begin
               mon_e = sbq.pop_front();
               chk("wr_hold_cycles", hold_cnt, mon_e.hold);
               hold_cnt = 0;
            end
         end
      end
      if (done === 1'b1) begin
         if (sbq.size() == 0 || !sbq[0].is_done) begin
            fail_now("unexpected_done", "done pulse, expected none");
         end else begin
            mon_e = sbq.pop_front();
            chk("done_error", {31'b0, error}, {31'b0, mon_e.err});
            chk("done_sector_index", {24'b0, sector_index}, mon_e.sidx);
            chk("done_byte_index", {23'b0, byte_index}, mon_e.bidx);
            if (mon_e.at >= 0) chk("done_cycle", cyc, mon_e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the cycle in which the request was accepted.
   task automatic issue(input bit w, input logic [11:0] lba, input logic [7:0] cnt, output int acc);
      int n;
      n = 0;
      req_write = w;
      req_lba   = lba;
      req_count = cnt;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_now("accept_timeout", "req_ready never high");
      acc = cyc;
      tick();
      req_valid = 1'b0;
   endtask

   // Leaves the bench in the first XFER cycle after the control write.
   task automatic wait_ctrl();
      int n;
      n = 0;
      while (!(sd_master_write === 1'b1 && sd_master_address == 32'd12 &&
               sd_master_waitrequest == 1'b0) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_now("ctrl_timeout", "no control write");
      tick();
   endtask

   task automatic strobes(input int n, input bit use_rd, output int last);
      last = cyc;
      for (int i = 0; i < n; i++) begin
         if (use_rd) sd_slave_read = 1'b1;
         else        sd_slave_write = 1'b1;
         last = cyc;
         tick();
      end
      sd_slave_read  = 1'b0;
      sd_slave_write = 1'b0;
   endtask

   task automatic wait_empty(input int max);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < max) begin
         tick();
         n++;
      end
      if (sbq.size() != 0) fail_now("scoreboard_drain", $sformatf("%0d entries pending, expected 0", sbq.size()));
   endtask

   initial begin
      int acc, last;

      // Reset state
      tick();
      tick();
      chk("rst_ready", {31'b0, req_ready}, 1);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_error", {31'b0, error}, 0);
      chk("rst_mwrite", {31'b0, sd_master_write}, 0);
      chk("rst_addr", sd_master_address, 0);
      chk("rst_wdata", sd_master_writedata, 0);
      chk("rst_sidx", {24'b0, sector_index}, 0);
      chk("rst_bidx", {23'b0, byte_index}, 0);
      rst = 1'b0;
      tick();

      // Read lba=5, one sector, no stalls
      push_wr(0, BASE_V, 1); push_wr(4, 5, 1); push_wr(8, 1, 1); push_wr(12, 2, 1);
      issue(1'b0, 12'd5, 8'd1, acc);
      wait_ctrl();
      chk("xfer_entry_cycle", cyc, acc + 5);
      strobes(512, 1'b0, last);
      push_done(1'b0, 1, 0, last + 3);
      wait_empty(20);

      // Write lba=4095, two sectors; sector number wraps; req_valid while busy ignored
      push_wr(0, BASE_V, 1); push_wr(4, 4095, 1); push_wr(8, 1, 1); push_wr(12, 3, 1);
      push_wr(4, 0, 1); push_wr(8, 1, 1); push_wr(12, 3, 1);
      issue(1'b1, 12'd4095, 8'd2, acc);
      wait_ctrl();
      req_lba = 12'd77; req_count = 8'd9; req_write = 1'b0; req_valid = 1'b1;
      chk("ready_while_busy", {31'b0, req_ready}, 0);
      strobes(256, 1'b1, last);
      chk("mid_byte_index", {23'b0, byte_index}, 256);
      strobes(256, 1'b1, last);
      req_valid = 1'b0;
      wait_ctrl();
      strobes(512, 1'b1, last);
      push_done(1'b0, 2, 0, last + 3);
      wait_empty(20);

      // Waitrequest held 3 cycles on the count write
      push_wr(0, BASE_V, 1); push_wr(4, 7, 1); push_wr(8, 1, 4); push_wr(12, 2, 1);
      issue(1'b0, 12'd7, 8'd1, acc);
      begin
         int n;
         n = 0;
         while (sd_master_address != 32'd8 && n < 20) begin tick(); n++; end
         if (n >= 20) fail_now("cnt_wait", "no count write");
      end
      sd_master_waitrequest = 1'b1;
      tick(); tick(); tick();
      sd_master_waitrequest = 1'b0;
      wait_ctrl();
      strobes(512, 1'b0, last);
      push_done(1'b0, 1, 0, last + 3);
      wait_empty(20);

      // Strobes stop after 100 bytes: timeout
      push_wr(0, BASE_V, 1); push_wr(4, 9, 1); push_wr(8, 1, 1); push_wr(12, 2, 1);
      issue(1'b0, 12'd9, 8'd1, acc);
      wait_ctrl();
      strobes(100, 1'b0, last);
      push_done(1'b1, 0, 100, last + TMO);
      wait_empty(40);
      tick(); tick();
      chk("error_sticky", {31'b0, error}, 1);
      chk("idle_after_tmo", {31'b0, busy}, 0);

      // Wrong-direction strobe on a write request
      push_wr(0, BASE_V, 1); push_wr(4, 3, 1); push_wr(8, 1, 1); push_wr(12, 3, 1);
      issue(1'b1, 12'd3, 8'd1, acc);
      wait_ctrl();
      chk("error_cleared_on_accept", {31'b0, error}, 0);
      strobes(1, 1'b0, last);
      push_done(1'b1, 0, 0, last + 1);
      wait_empty(10);

      // Reset in the middle of a 3-sector read
      push_wr(0, BASE_V, 1); push_wr(4, 100, 1); push_wr(8, 1, 1); push_wr(12, 2, 1);
      issue(1'b0, 12'd100, 8'd3, acc);
      wait_ctrl();
      strobes(50, 1'b0, last);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, busy}, 0);
      chk("midrst_ready", {31'b0, req_ready}, 1);
      chk("midrst_bidx", {23'b0, byte_index}, 0);
      chk("midrst_done", {31'b0, done}, 0);
      chk("midrst_mwrite", {31'b0, sd_master_write}, 0);
      tick();
      rst = 1'b0;
      tick(); tick();

      // count=0 after reset: done next cycle, no bus traffic, busy hold-off
      issue(1'b0, 12'd20, 8'd0, acc);
      push_done(1'b0, 0, 0, acc + 1);
      req_count = 8'd5; req_valid = 1'b1;
      chk("zero_busy", {31'b0, busy}, 1);
      chk("zero_ready", {31'b0, req_ready}, 0);
      tick();
      req_valid = 1'b0;
      tick(); tick();
      chk("zero_not_accepted", {31'b0, busy}, 0);
      wait_empty(10);

      tick(); tick(); tick();
      chk("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end

endmodule
